// File: rtl/chan_cnt_pkg.sv
// Shared constants and FSM state type for the channel event counter.
// Optional saturating counters are enabled with CHAN_CNT_SAT_EN.
package chan_cnt_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/chan_counter.sv
// One per-channel event counter with synchronous clear.
// Wraps by default; saturates at all-ones when CHAN_CNT_SAT_EN is defined.
module chan_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

`ifdef CHAN_CNT_SAT_EN
    logic w_at_max;
    assign w_at_max = &r_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
`ifdef CHAN_CNT_SAT_EN
            if (!w_at_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
`else
            r_cnt <= r_cnt + 1'b1;
`endif
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/chan_event_counter.sv
// Windowed 8-channel event counter with registered read port.
// Counter behaviour on overflow is selected by CHAN_CNT_SAT_EN.
module chan_event_counter
    import chan_cnt_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] y_in,
    input  logic              in_valid,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_busy;
    logic              r_done;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [WIN_W-1:0]  r_win;
    logic              w_win_end;
    logic              w_clr;
    logic [NUM_CH-1:0] w_inc;
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [CNT_W-1:0]  r_rd_data;
    logic              r_rd_valid;

    // A start is only honoured outside an active window.
    assign w_clr     = start && (r_state != COUNT);
    assign w_win_end = (r_win == WIN_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = COUNT;
            COUNT:   if (w_win_end) w_next = DONE;
            DONE:    if (start) w_next = COUNT;
            default: w_next = IDLE;
        endcase
    end

    // Flags are registered from the next state so they align with r_state.
    always_comb begin
        w_busy_nxt = (w_next == COUNT);
        w_done_nxt = (w_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_clr) begin
            r_win <= '0;
        end else if (r_state == COUNT) begin
            r_win <= r_win + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_inc[g] = (r_state == COUNT) && in_valid && y_in[g];

            chan_counter #(
                .CNT_W (CNT_W)
            ) u_chan_counter (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (w_clr),
                .inc   (w_inc[g]),
                .o_cnt (w_cnt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_cnt[rd_sel];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_chan_event_counter.sv
// Self-checking bench for chan_event_counter: window table, directed
// corner cases and randomized traffic against a reference model.
module tb_chan_event_counter;

    localparam int CNT_W   = 8;
    localparam int WIN_LEN = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] y_in;
    logic       in_valid;
    logic       rd_req;
    logic [2:0] rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;

    logic       start2;
    logic [7:0] y2;
    logic       v2;
    logic       rdreq2;
    logic [2:0] rdsel2;
    logic [3:0] rdata2;
    logic       rvalid2;
    logic       busy2;
    logic       done2;

    always #5 clk = ~clk;

    chan_event_counter #(
        .CNT_W   (CNT_W),
        .WIN_LEN (WIN_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .y_in     (y_in),
        .in_valid (in_valid),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done)
    );

    chan_event_counter #(
        .CNT_W   (4),
        .WIN_LEN (32)
    ) dut_ovf (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .y_in     (y2),
        .in_valid (v2),
        .rd_req   (rdreq2),
        .rd_sel   (rdsel2),
        .rd_data  (rdata2),
        .rd_valid (rvalid2),
        .busy     (busy2),
        .done     (done2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 counting, 2 done
    int m_phase = 0;
    int m_left  = 0;
    int m_cnt [8];
    int m_rd_data = 0;
    int m_rd_valid = 0;

    typedef struct {
        logic [7:0] ya;
        logic       va;
        int         na;
        logic [7:0] yb;
        logic       vb;
        int         nb;
        int         st_at;
        int         exp [8];
    } win_t;

    win_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_tick();
        if (!rst_n) begin
            m_phase = 0;
            m_left = 0;
            m_rd_data = 0;
            m_rd_valid = 0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
        end else begin
            m_rd_valid = rd_req ? 1 : 0;
            if (rd_req) m_rd_data = m_cnt[rd_sel];
            if (m_phase == 1) begin
                if (in_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        if (y_in[k]) begin
`ifdef CHAN_CNT_SAT_EN
                            if (m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
`else
                            m_cnt[k] = (m_cnt[k] + 1) % (CMAX + 1);
`endif
                        end
                    end
                end
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end else if (start) begin
                foreach (m_cnt[k]) m_cnt[k] = 0;
                m_phase = 1;
                m_left = WIN_LEN;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        chk("model busy", int'(busy), (m_phase == 1) ? 1 : 0);
        chk("model done", int'(done), (m_phase == 2) ? 1 : 0);
        chk("model rd_valid", int'(rd_valid), m_rd_valid);
        chk("model rd_data", int'(rd_data), m_rd_data);
    endtask

    task automatic idle_in();
        start = 1'b0;
        y_in = 8'h00;
        in_valid = 1'b0;
        rd_req = 1'b0;
        rd_sel = 3'd0;
    endtask

    task automatic run_window(input int idx, input win_t w);
        idle_in();
        start = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("w%0d busy after start", idx), int'(busy), 1);
        for (int j = 1; j <= WIN_LEN; j++) begin
            if (j <= w.na) begin
                y_in = w.ya;
                in_valid = w.va;
            end else if (j <= w.na + w.nb) begin
                y_in = w.yb;
                in_valid = w.vb;
            end else begin
                y_in = 8'h00;
                in_valid = 1'b0;
            end
            start = (j == w.st_at);
            step();
            chk($sformatf("w%0d busy c%0d", idx, j), int'(busy),
                (j < WIN_LEN) ? 1 : 0);
            chk($sformatf("w%0d done c%0d", idx, j), int'(done),
                (j == WIN_LEN) ? 1 : 0);
        end
        idle_in();
        for (int k = 0; k < 8; k++) begin
            rd_req = 1'b1;
            rd_sel = 3'(k);
            step();
            chk($sformatf("w%0d ch%0d data", idx, k), int'(rd_data), w.exp[k]);
            chk($sformatf("w%0d ch%0d valid", idx, k), int'(rd_valid), 1);
        end
        rd_req = 1'b0;
        step();
        chk($sformatf("w%0d valid drop", idx), int'(rd_valid), 0);
        chk($sformatf("w%0d data hold", idx), int'(rd_data), w.exp[7]);
    endtask

    initial begin
        tbl[0] = '{8'h04, 1'b1, 10, 8'h00, 1'b0, 0, 0,
                   '{0, 0, 10, 0, 0, 0, 0, 0}};
        tbl[1] = '{8'hFF, 1'b0, 5, 8'h81, 1'b1, 3, 0,
                   '{3, 0, 0, 0, 0, 0, 0, 3}};
        tbl[2] = '{8'h55, 1'b1, 7, 8'hAA, 1'b1, 4, 6,
                   '{7, 4, 7, 4, 7, 4, 7, 4}};
        tbl[3] = '{8'hFF, 1'b0, 16, 8'h00, 1'b0, 0, 0,
                   '{0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[4] = '{8'hFF, 1'b1, 16, 8'h00, 1'b0, 0, 0,
                   '{16, 16, 16, 16, 16, 16, 16, 16}};

        start2 = 1'b0;
        y2 = 8'h00;
        v2 = 1'b0;
        rdreq2 = 1'b0;
        rdsel2 = 3'd0;

        // Reset with start/rd_req asserted: reset must win
        idle_in();
        rst_n = 1'b0;
        start = 1'b1;
        rd_req = 1'b1;
        step();
        step();
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        idle_in();
        rd_req = 1'b1;
        rd_sel = 3'd0;
        step();
        chk("post-reset rd_data", int'(rd_data), 0);
        chk("post-reset rd_valid", int'(rd_valid), 1);
        chk("post-reset busy", int'(busy), 0);
        chk("post-reset done", int'(done), 0);
        idle_in();
        step();

        for (int i = 0; i < 5; i++) run_window(i, tbl[i]);

        // Read during counting returns the pre-increment value, then reset
        idle_in();
        start = 1'b1;
        step();
        start = 1'b0;
        y_in = 8'h02;
        in_valid = 1'b1;
        for (int j = 0; j < 5; j++) step();
        rd_req = 1'b1;
        rd_sel = 3'd1;
        step();
        chk("rd during inc #1", int'(rd_data), 5);
        step();
        chk("rd during inc #2", int'(rd_data), 6);
        chk("rd during inc valid", int'(rd_valid), 1);
        idle_in();
        rst_n = 1'b0;
        step();
        chk("mid-count reset busy", int'(busy), 0);
        chk("mid-count reset done", int'(done), 0);
        rst_n = 1'b1;
        rd_req = 1'b1;
        rd_sel = 3'd1;
        step();
        chk("mid-count reset ch1", int'(rd_data), 0);
        idle_in();
        step();

        // Overflow on the narrow instance
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        y2 = 8'h80;
        for (int j = 1; j <= 32; j++) begin
            v2 = (j <= 20);
            step();
        end
        v2 = 1'b0;
        chk("ovf done", int'(done2), 1);
        chk("ovf busy", int'(busy2), 0);
        rdreq2 = 1'b1;
        rdsel2 = 3'd7;
        step();
        rdreq2 = 1'b0;
        chk("ovf rd_valid", int'(rvalid2), 1);
`ifdef CHAN_CNT_SAT_EN
        chk("ovf ch7 saturate", int'(rdata2), 15);
`else
        chk("ovf ch7 wrap", int'(rdata2), 4);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            start = ($urandom_range(0, 11) == 0);
            y_in = 8'($urandom);
            in_valid = $urandom_range(0, 1) == 1;
            rd_req = $urandom_range(0, 1) == 1;
            rd_sel = 3'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chan_event_counter.md
CHAN_EVENT_COUNTER -- requirements
Module: chan_event_counter

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-channel counter and of rd_data.
REQ-002 Parameter WIN_LEN, default 256: measurement window length in clock cycles, legal range 2 to 65536.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that arms a new measurement window.
REQ-006 y_in  input  8  channel lines from the upstream 1:8 demux output.
REQ-007 in_valid  input  1  qualifies y_in for the current cycle.
REQ-008 rd_req  input  1  single-cycle read request.
REQ-009 rd_sel  input  3  channel index to read.
REQ-010 rd_data  output  CNT_W  registered count of the selected channel.
REQ-011 rd_valid  output  1  single-cycle pulse marking rd_data as valid.
REQ-012 busy  output  1  high while the window is counting.
REQ-013 done  output  1  high while a completed window result is held.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, COUNT and DONE; busy = (state==COUNT) and done = (state==DONE), both driven from registers.
REQ-015 When start=1 in IDLE or DONE, the block SHALL clear all 8 counters and the window counter and enter COUNT on the next cycle.
REQ-016 When start=1 in COUNT, the block SHALL ignore it, with no clear and no restart.
REQ-017 In each COUNT cycle, the block SHALL increment cnt[k] by 1 for every k with in_valid=1 and y_in[k]=1, treating all channels independently (one-hot input is not enforced).
REQ-018 When in_valid=0, the block SHALL make no counter change, whatever the value of y_in.
REQ-019 The window counter SHALL increment once per COUNT cycle; the cycle in which it equals WIN_LEN-1 SHALL still count, and the FSM SHALL then enter DONE, giving exactly WIN_LEN counting cycles.
REQ-020 In DONE and IDLE, the counters SHALL hold their values.
REQ-021 When rd_req=1 (sampled in any state), the block SHALL present cnt[rd_sel] on rd_data with rd_valid=1 on the next cycle, giving a latency of 1.
REQ-022 A read in the same cycle as an increment SHALL return the pre-increment value.
REQ-023 rd_data SHALL hold its last value while rd_valid=0.
REQ-024 Back-to-back rd_req on consecutive cycles SHALL each produce one rd_valid pulse.
REQ-025 On counter overflow, the counter SHALL wrap modulo 2^CNT_W (default build).

Reset
REQ-026 When rst_n=0 at a rising clk edge, the block SHALL set state to IDLE and clear all counters, the window counter, rd_data, rd_valid, busy and done to 0.
REQ-027 Reset mid-COUNT SHALL abort the window; no partial result is retained.
REQ-028 Reset SHALL take priority over start and rd_req in the same cycle.

Configuration
REQ-029 The block SHALL support the macro CHAN_CNT_SAT_EN.
REQ-030 With CHAN_CNT_SAT_EN defined, each counter SHALL saturate at 2^CNT_W-1 and stop incrementing.
REQ-031 With CHAN_CNT_SAT_EN undefined, each counter SHALL wrap per REQ-025.
REQ-032 The port list SHALL be identical in both builds.

Structure
REQ-033 Package chan_cnt_pkg SHALL hold NUM_CH=8, SEL_W=3 and the FSM state enum (IDLE, COUNT, DONE).
REQ-034 Sub-module chan_counter SHALL implement one channel, with inputs clr, inc and the saturate/wrap behaviour, and SHALL be instantiated 8 times via generate.
REQ-035 The top level SHALL own the FSM, the window counter and the read mux/register.

Verification (CNT_W=8, WIN_LEN=16 unless stated)
REQ-036 Reset: drive rst_n=0 for 2 cycles, then rd_req with rd_sel=0 -> rd_data=0, rd_valid=1 one cycle later, busy=0 and done=0.
REQ-037 Single channel: start at t0, then y_in=8'h04 with in_valid=1 for 10 cycles -> busy over t1..t16, done from t17, reading rd_sel=2 returns 10, and all other channels return 0.
REQ-038 Gating and multi-hot: y_in=8'hFF with in_valid=0 for 5 cycles, then y_in=8'h81 with in_valid=1 for 3 cycles -> ch0=3, ch7=3, and all others 0.
REQ-039 Overflow: CNT_W=4, WIN_LEN=32, y_in=8'h80 with in_valid=1 for 20 cycles -> ch7 reads 4 without CHAN_CNT_SAT_EN and 15 with it.
REQ-040 Start during COUNT is ignored, and window length stays 16 cycles; a second start in DONE clears all channels to 0.
REQ-041 Read during COUNT with in_valid=1 on ch1 -> rd_data equals the count before that cycle's increment; rst_n=0 mid-COUNT -> next cycle state=IDLE and all counters read 0.
